// File: rtl/booth_mul_sched_pkg.sv
// Shared types and sizing helpers for the Booth multiplier scheduler.
package booth_mul_sched_pkg;

  // Scheduler states, walked strictly in this order.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_LOAD_M = 3'd2,
    S_LOAD_Q = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam int W_DEF = 16;

  // Product of two w-bit operands is 2w bits ({A,Q} from the multiplier).
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   j;

  // Scan from the pointer, wrapping; grant is forced to zero outside IDLE.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one Booth multiplier between NREQ requesters: start, M, Q sequencing,
// done/timeout handling and one-hot response routing.
module booth_mul_sched
  import booth_mul_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        op_a,
  input  logic [NREQ*W-1:0]        op_b,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [prod_w(W)-1:0]     rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [W-1:0]             mul_data,
  input  logic                     mul_done,
  input  logic [prod_w(W)-1:0]     mul_product
);

  localparam int PW   = prod_w(W);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d, sel_idx;
  logic [W-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt;

  logic [NREQ-1:0] ack_q, ack_d, rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d, busy_q, busy_d, mul_start_q, mul_start_d;
  logic [W-1:0]    mul_data_q, mul_data_d;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .en  (state_q == S_IDLE),
    .gnt (gnt)
  );

  // One-hot grant to binary index.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) sel_idx = IW'(i);
  end

  // Next-state logic plus outputs decoded from the state being entered,
  // so the registered outputs line up with the registered state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (|req) begin
        state_d = S_START;
        idx_d   = sel_idx;
        opa_d   = op_a[int'(sel_idx)*W +: W];
        opb_d   = op_b[int'(sel_idx)*W +: W];
        ptr_d   = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
      end
      S_START:  state_d = S_LOAD_M;
      S_LOAD_M: state_d = S_LOAD_Q;
      S_LOAD_Q: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // done takes priority over an expiring watchdog in the same cycle
        if (mul_done) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    mul_start_d = (state_d == S_START);
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    mul_data_d  = '0;
    case (state_d)
      S_START:  ack_d[idx_d] = 1'b1;
      S_LOAD_M: mul_data_d = opa_d;
      S_LOAD_Q: mul_data_d = opb_d;
      S_RESP: begin
        rsp_valid_d[idx_d] = 1'b1;
        rsp_err_d          = err_d;
        rsp_data_d         = prod_d;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      prod_q      <= prod_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
      mul_data_q  <= mul_data_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_data  = mul_data_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched; the multiplier side is driven by hand.
module tb_booth_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] op_a, op_b;
  logic [1:0]  ack, rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err, busy, mul_start;
  logic [15:0] mul_data;
  logic        mul_done;
  logic [31:0] mul_product;

  int total = 0;
  int bad   = 0;

  booth_mul_sched #(.W(16), .NREQ(2), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .op_a        (op_a),
    .op_b        (op_b),
    .ack         (ack),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_data    (mul_data),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runs one job starting from an IDLE cycle in which req is already set.
  // dly = WAIT cycle index on which done is presented; done_en=0 means never.
  task automatic job(input logic [1:0] g, input logic [1:0] req_after,
                     input logic [15:0] a, input logic [15:0] b,
                     input int dly, input logic done_en, input logic spur,
                     input logic [31:0] prod, input logic [31:0] exp_data,
                     input logic exp_err);
    tick();
    chk("ack", 64'(ack), 64'(g));
    chk("mul_start", 64'(mul_start), 64'(1));
    chk("busy_start", 64'(busy), 64'(1));
    chk("data_start", 64'(mul_data), 64'(0));
    req = req_after;
    tick();
    chk("mul_m", 64'(mul_data), 64'(a));
    chk("start_lo", 64'(mul_start), 64'(0));
    chk("ack_lo", 64'(ack), 64'(0));
    if (spur) begin
      mul_done    = 1'b1;
      mul_product = 32'h1234_5678;
    end
    tick();
    mul_done = 1'b0;
    chk("mul_q", 64'(mul_data), 64'(b));
    chk("no_rsp_q", 64'(rsp_valid), 64'(0));
    tick();
    chk("wait_data", 64'(mul_data), 64'(0));
    if (done_en) begin
      repeat (dly) tick();
      chk("wait_busy", 64'(busy), 64'(1));
      chk("wait_norsp", 64'(rsp_valid), 64'(0));
      mul_done    = 1'b1;
      mul_product = prod;
      tick();
      mul_done    = 1'b0;
    end else begin
      mul_product = 32'hDEAD_BEEF;
      repeat (63) tick();
      chk("to_busy63", 64'(busy), 64'(1));
      chk("to_norsp63", 64'(rsp_valid), 64'(0));
      tick();
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(g));
    chk("rsp_data", 64'(rsp_data), 64'(exp_data));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    tick();
    chk("idle_rsp_lo", 64'(rsp_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_err", 64'(rsp_err), 64'(0));
    chk("rsp_hold", 64'(rsp_data), 64'(exp_data));
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; op_a = '0; op_b = '0;
    mul_done = 1'b0; mul_product = '0;
    tick(); tick();
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_data", 64'(rsp_data), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_start", 64'(mul_start), 64'(0));
    chk("rst_mdata", 64'(mul_data), 64'(0));
    rst_n = 1'b1;
    tick();

    // single job: 15 * -10 = -150
    req = 2'b01; op_a = {16'd0, 16'd15}; op_b = {16'd0, 16'hFFF6};
    job(2'b01, 2'b00, 16'd15, 16'hFFF6, 2, 1'b1, 1'b0,
        32'hFFFF_FF6A, 32'hFFFF_FF6A, 1'b0);

    // watchdog: done never comes
    req = 2'b01; op_a = {16'd0, 16'd9}; op_b = {16'd0, 16'd9};
    job(2'b01, 2'b00, 16'd9, 16'd9, 0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

    // recovery after timeout: 5 * 6 = 30
    req = 2'b01; op_a = {16'd0, 16'd5}; op_b = {16'd0, 16'd6};
    job(2'b01, 2'b00, 16'd5, 16'd6, 0, 1'b1, 1'b0, 32'd30, 32'd30, 1'b0);

    // done on the last watchdog cycle wins: 100 * -3 = -300
    req = 2'b10; op_a = {16'd100, 16'd0}; op_b = {16'hFFFD, 16'd0};
    job(2'b10, 2'b00, 16'd100, 16'hFFFD, 63, 1'b1, 1'b0,
        32'hFFFF_FED4, 32'hFFFF_FED4, 1'b0);

    // spurious done in IDLE, then in LOAD_M; real done accepted later
    req = 2'b00; mul_done = 1'b1; mul_product = 32'h0BAD_0BAD;
    tick();
    mul_done = 1'b0;
    tick();
    chk("spur_busy", 64'(busy), 64'(0));
    chk("spur_rsp", 64'(rsp_valid), 64'(0));
    chk("spur_ack", 64'(ack), 64'(0));
    req = 2'b01; op_a = {16'd0, 16'd2}; op_b = {16'd0, 16'd21};
    job(2'b01, 2'b00, 16'd2, 16'd21, 3, 1'b1, 1'b1, 32'd42, 32'd42, 1'b0);

    // reset mid-WAIT after a grant to 0 (pointer would otherwise be 1)
    req = 2'b01; op_a = {16'd0, 16'd8}; op_b = {16'd0, 16'd8};
    tick();
    chk("rw_ack", 64'(ack), 64'(1));
    req = 2'b00;
    tick(); tick(); tick(); tick();
    chk("rw_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick();
    chk("rw_busy0", 64'(busy), 64'(0));
    chk("rw_rsp0", 64'(rsp_valid), 64'(0));
    chk("rw_data0", 64'(rsp_data), 64'(0));
    chk("rw_start0", 64'(mul_start), 64'(0));
    chk("rw_mdata0", 64'(mul_data), 64'(0));
    chk("rw_ack0", 64'(ack), 64'(0));
    rst_n = 1'b1;

    // contention, held req=11: order 0,1,0,1
    req = 2'b11; op_a = {16'd7, 16'd3}; op_b = {16'hFFFE, 16'd4};
    job(2'b01, 2'b11, 16'd3, 16'd4, 1, 1'b1, 1'b0, 32'd12, 32'd12, 1'b0);
    job(2'b10, 2'b11, 16'd7, 16'hFFFE, 2, 1'b1, 1'b0,
        32'hFFFF_FFF2, 32'hFFFF_FFF2, 1'b0);
    job(2'b01, 2'b11, 16'd3, 16'd4, 0, 1'b1, 1'b0, 32'd12, 32'd12, 1'b0);
    job(2'b10, 2'b00, 16'd7, 16'hFFFE, 4, 1'b1, 1'b0,
        32'hFFFF_FFF2, 32'hFFFF_FFF2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
